// File: rtl/dom_mask_rng.sv
// ============================================================================
// Module : dom_mask_rng
// Brief  : Seeded 32-bit Galois LFSR supplying z0/z1 mask pairs to DOM GF(2^2)
//          multipliers over a valid/ready handshake, one word per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dom_mask_rng #(
    parameter int unsigned NUM_MULT = 4,
    parameter int unsigned WARMUP   = 16,
    parameter logic [31:0] ZERO_SUB = 32'hACE1ACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    seed_valid,
    input  logic [31:0]             seed_data,
    output logic                    busy,
    output logic                    rnd_valid,
    input  logic                    rnd_ready,
    output logic [4*NUM_MULT-1:0]   rnd_data
);

    localparam int unsigned ZW   = 4 * NUM_MULT;
    localparam logic [31:0] POLY = 32'h80200003;
    localparam int unsigned CW   = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEED   = 2'd1,
        S_WARMUP = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t          state;
    logic [31:0]     lfsr;
    logic [31:0]     lfsr_adv;
    logic [CW-1:0]   warm_cnt;

    // ZW chained single steps so each advance yields ZW fresh bits.
    always_comb begin
        lfsr_adv = lfsr;
        for (int i = 0; i < int'(ZW); i++) begin
            lfsr_adv = (lfsr_adv >> 1) ^ (lfsr_adv[0] ? POLY : 32'h0);
        end
    end

    assign busy = (state == S_SEED) || (state == S_WARMUP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lfsr      <= ZERO_SUB;
            warm_cnt  <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
        end else if (seed_valid) begin
            // A seed request overrides everything, including a live handshake.
            lfsr      <= (seed_data == 32'h0) ? ZERO_SUB : seed_data;
            warm_cnt  <= CW'(WARMUP);
            rnd_valid <= 1'b0;
            state     <= S_SEED;
        end else begin
            case (state)
                S_IDLE: begin
                    rnd_valid <= 1'b0;
                end
                S_SEED: begin
                    state <= S_WARMUP;
                end
                S_WARMUP: begin
                    lfsr <= lfsr_adv;
                    if (warm_cnt != '0) begin
                        warm_cnt <= warm_cnt - 1'b1;
                    end else begin
                        rnd_data  <= lfsr_adv[ZW-1:0];
                        rnd_valid <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rnd_ready) begin
                        lfsr     <= lfsr_adv;
                        rnd_data <= lfsr_adv[ZW-1:0];
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    rnd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dom_mask_rng.sv
// ============================================================================
// Module : tb_dom_mask_rng
// Brief  : Scoreboard bench for dom_mask_rng (NUM_MULT=1/WARMUP=0 and default).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dom_mask_rng;

    localparam logic [31:0] ZSUB = 32'hACE1ACE1;

    logic        clk;
    logic        rst_n;

    logic        seed_valid1, rnd_ready1, rnd_valid1, busy1;
    logic [31:0] seed_data1;
    logic [3:0]  rnd_data1;

    logic        seed_valid4, rnd_ready4, rnd_valid4, busy4;
    logic [31:0] seed_data4;
    logic [15:0] rnd_data4;

    int total = 0;
    int bad   = 0;
    int pops1 = 0;
    int pops4 = 0;

    logic [3:0]  q1[$];
    logic [15:0] q4[$];

    dom_mask_rng #(.NUM_MULT(1), .WARMUP(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(seed_valid1), .seed_data(seed_data1), .busy(busy1),
        .rnd_valid(rnd_valid1), .rnd_ready(rnd_ready1), .rnd_data(rnd_data1)
    );

    dom_mask_rng u4 (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(seed_valid4), .seed_data(seed_data4), .busy(busy4),
        .rnd_valid(rnd_valid4), .rnd_ready(rnd_ready4), .rnd_data(rnd_data4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] adv(input logic [31:0] s, input int zw);
        for (int i = 0; i < zw; i++) s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push4(input logic [31:0] seed, input int n);
        logic [31:0] s;
        s = (seed == 32'h0) ? ZSUB : seed;
        repeat (16) s = adv(s, 16);
        for (int i = 0; i < n; i++) begin
            s = adv(s, 16);
            q4.push_back(s[15:0]);
        end
    endtask

    // Monitors: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && rnd_valid1 && rnd_ready1) begin
            pops1++;
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL word1: got unexpected %h, expected none", rnd_data1);
            end else begin
                chk("word1", 32'(rnd_data1), 32'(q1.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rnd_valid4 && rnd_ready4) begin
            pops4++;
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL word4: got unexpected %h, expected none", rnd_data4);
            end else begin
                chk("word4", 32'(rnd_data4), 32'(q4.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] s;
        int base;
        int gap;

        rst_n = 1'b0;
        seed_valid1 = 1'b0; seed_data1 = '0; rnd_ready1 = 1'b0;
        seed_valid4 = 1'b0; seed_data4 = '0; rnd_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: nothing moves without a seed.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid1", 32'(rnd_valid1), 32'd0);
            chk("idle_data1",  32'(rnd_data1),  32'd0);
            chk("idle_busy1",  32'(busy1),      32'd0);
            chk("idle_valid4", 32'(rnd_valid4), 32'd0);
            chk("idle_data4",  32'(rnd_data4),  32'd0);
            chk("idle_busy4",  32'(busy4),      32'd0);
        end

        // Seed 1, WARMUP=0: first word 3, then 2, then 1; backpressure holds.
        @(posedge clk);
        #1 seed_valid1 = 1'b1; seed_data1 = 32'h00000001;
        @(posedge clk);
        #1 seed_valid1 = 1'b0;
        q1.push_back(4'h3); q1.push_back(4'h2); q1.push_back(4'h1);
        chk("seed_busy1",  32'(busy1),      32'd1);
        chk("seed_valid1", 32'(rnd_valid1), 32'd0);
        @(posedge clk);
        #1 chk("warm_valid1", 32'(rnd_valid1), 32'd0);
        chk("warm_busy1",  32'(busy1), 32'd1);
        @(posedge clk);
        #1 chk("first_valid1", 32'(rnd_valid1), 32'd1);
        chk("first_busy1", 32'(busy1), 32'd0);
        chk("first_z0",    32'(rnd_data1[1:0]), 32'd3);
        chk("first_z1",    32'(rnd_data1[3:2]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("hold_data1",  32'(rnd_data1),  32'h3);
            chk("hold_valid1", 32'(rnd_valid1), 32'd1);
        end
        base = pops1;
        rnd_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rnd_ready1 = 1'b0;
        chk("stream1_count", 32'(pops1 - base), 32'd3);
        chk("stream1_left",  32'(q1.size()),    32'd0);

        // Zero seed from RUN: stream equals that of ZERO_SUB.
        seed_valid1 = 1'b1; seed_data1 = 32'h0;
        @(posedge clk);
        #1 seed_valid1 = 1'b0;
        chk("reseed_drop1", 32'(rnd_valid1), 32'd0);
        q1.delete();
        s = ZSUB;
        for (int i = 0; i < 8; i++) begin
            s = adv(s, 4);
            q1.push_back(s[3:0]);
        end
        base = pops1;
        rnd_ready1 = 1'b1;
        repeat (10) @(posedge clk);
        #1 rnd_ready1 = 1'b0;
        chk("zero_seed_count", 32'(pops1 - base), 32'd8);
        chk("zero_seed_left",  32'(q1.size()),    32'd0);

        // Default parameters: warm-up latency, then reseed in RUN with ready high.
        rnd_ready4 = 1'b1;
        seed_valid4 = 1'b1; seed_data4 = 32'h12345678;
        @(posedge clk);
        #1 seed_valid4 = 1'b0;
        push4(32'h12345678, 20);
        chk("w_busy4", 32'(busy4), 32'd1);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1 chk("w_valid4", 32'(rnd_valid4), 32'd0);
            chk("w_busy4", 32'(busy4), 32'd1);
        end
        @(posedge clk);
        #1 chk("w_rise4", 32'(rnd_valid4), 32'd1);
        chk("w_busy_end4", 32'(busy4), 32'd0);
        base = pops4;
        repeat (8) @(posedge clk);
        #1 seed_valid4 = 1'b1;
        @(posedge clk);
        #1 seed_valid4 = 1'b0;
        chk("run1_count4",   32'(pops4 - base), 32'd9);
        chk("reseed_valid4", 32'(rnd_valid4),   32'd0);
        chk("reseed_busy4",  32'(busy4),        32'd1);
        q4.delete();
        push4(32'h12345678, 20);
        base = pops4;
        repeat (17) @(posedge clk);
        #1 chk("rerun_valid_lo4", 32'(rnd_valid4), 32'd0);
        @(posedge clk);
        #1 chk("rerun_valid_hi4", 32'(rnd_valid4), 32'd1);
        repeat (5) @(posedge clk);
        #1 rnd_ready4 = 1'b0;
        chk("rerun_count4", 32'(pops4 - base), 32'd5);

        // Soak: random ready and reseeds (zero seeds included).
        seed_valid4 = 1'b1; seed_data4 = 32'h0;
        gap = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            #1;
            if (seed_valid4) begin
                q4.delete();
                push4(seed_data4, 300);
                gap = 0;
            end else begin
                gap++;
            end
            seed_valid4 = ($urandom_range(0, 63) == 0) || (gap >= 200);
            seed_data4  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            rnd_ready4  = ($urandom_range(0, 3) != 0);
        end
        seed_valid4 = 1'b0; rnd_ready4 = 1'b0;
        chk("soak_activity", 32'(pops4 > 1000), 32'd1);
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
